// File: rtl/rf_psum_drain_pkg.sv
// Shared definitions for the partial-sum register file: drain FSM state
// encoding, default widths and the entry-count derivation.
package rf_psum_drain_pkg;

    localparam int DEF_OUT_BITWIDTH       = 16;
    localparam int DEF_PSUM_ADDR_BITWIDTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } psum_state_e;

    // Number of entries addressable with an aw-bit address.
    function automatic int psum_depth(input int aw);
        return 32'sd1 << aw;
    endfunction

endpackage : rf_psum_drain_pkg

// File: rtl/rf_psum_mem.sv
// Partial-sum storage array: one synchronous write port, two combinational
// read ports (MAC feedback and drain), a clear-all and a clear-one input.
// Priority on an edge: clear-all, then clear-one, then write.
module rf_psum_mem
    import rf_psum_drain_pkg::*;
#(
    parameter int W  = DEF_OUT_BITWIDTH,
    parameter int AW = DEF_PSUM_ADDR_BITWIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_all,
    input  logic          clr_one,
    input  logic [AW-1:0] clr_idx,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_a_addr,
    output logic [W-1:0]  rd_a_data,
    input  logic [AW-1:0] rd_b_addr,
    output logic [W-1:0]  rd_b_data
);

    localparam int DEPTH = psum_depth(AW);

    logic [W-1:0] mem_r [DEPTH];

    // Storage update: async zero on reset, then clear-all / clear-one / write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else if (clr_all) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else if (clr_one) begin
            mem_r[clr_idx] <= {W{1'b0}};
        end else if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_a_data = mem_r[rd_a_addr];
    assign rd_b_data = mem_r[rd_b_addr];

endmodule : rf_psum_mem

// File: rtl/rf_psum_drain.sv
// Partial-sum register file with MAC feedback read port and a drain FSM that
// streams every entry to the global buffer over valid/ready, zeroing each
// entry as it is accepted.
// Optional build macro: RF_PSUM_BYPASS_EN enables write-through forwarding of
// psum_in onto sum_out when an IDLE write targets read_addr.
module rf_psum_drain
    import rf_psum_drain_pkg::*;
#(
    parameter int OUT_BITWIDTH       = DEF_OUT_BITWIDTH,
    parameter int PSUM_ADDR_BITWIDTH = DEF_PSUM_ADDR_BITWIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [OUT_BITWIDTH-1:0]       psum_in,
    input  logic [PSUM_ADDR_BITWIDTH-1:0] write_addr,
    input  logic                          out_en,
    input  logic [PSUM_ADDR_BITWIDTH-1:0] read_addr,
    output logic [OUT_BITWIDTH-1:0]       sum_out,
    input  logic                          clear,
    input  logic                          drain_start,
    output logic [OUT_BITWIDTH-1:0]       drain_data,
    output logic [PSUM_ADDR_BITWIDTH-1:0] drain_addr,
    output logic                          drain_valid,
    input  logic                          drain_ready,
    output logic                          drain_done,
    output logic                          busy,
    output logic                          wr_conflict
);

    localparam int AW    = PSUM_ADDR_BITWIDTH;
    localparam int W     = OUT_BITWIDTH;
    localparam int DEPTH = psum_depth(AW);

    localparam logic [AW-1:0] ZERO_IDX = AW'(0);
    localparam logic [AW-1:0] ONE_IDX  = AW'(1);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    psum_state_e   state_r;
    logic [AW-1:0] idx_r;
    logic [W-1:0]  drain_data_r;
    logic [AW-1:0] drain_addr_r;
    logic          drain_valid_r;
    logic          drain_done_r;
    logic          busy_r;
    logic          wr_conflict_r;

    logic          mem_clr_all_s;
    logic          mem_clr_one_s;
    logic          mem_wr_en_s;
    logic [AW-1:0] mem_rd_b_addr_s;
    logic [W-1:0]  mem_rd_a_data_s;
    logic [W-1:0]  mem_rd_b_data_s;
    logic          handshake_s;
    logic          wr_drop_s;
    logic [W-1:0]  start_data_s;
    logic [W-1:0]  sum_out_s;

    rf_psum_mem #(
        .W  (W),
        .AW (AW)
    ) u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_all   (mem_clr_all_s),
        .clr_one   (mem_clr_one_s),
        .clr_idx   (idx_r),
        .wr_en     (mem_wr_en_s),
        .wr_addr   (write_addr),
        .wr_data   (psum_in),
        .rd_a_addr (read_addr),
        .rd_a_data (mem_rd_a_data_s),
        .rd_b_addr (mem_rd_b_addr_s),
        .rd_b_data (mem_rd_b_data_s)
    );

    // Per-state memory control: writes only land in IDLE without clear,
    // the drain port looks one entry ahead of idx while draining.
    always_comb begin
        mem_clr_all_s   = 1'b0;
        mem_clr_one_s   = 1'b0;
        mem_wr_en_s     = 1'b0;
        mem_rd_b_addr_s = ZERO_IDX;
        handshake_s     = 1'b0;
        wr_drop_s       = 1'b0;
        case (state_r)
            IDLE: begin
                mem_clr_all_s = clear;
                mem_wr_en_s   = out_en & ~clear;
                wr_drop_s     = out_en & clear;
            end
            DRAIN: begin
                handshake_s     = drain_valid_r & drain_ready;
                mem_clr_one_s   = handshake_s;
                mem_rd_b_addr_s = idx_r + ONE_IDX;
                wr_drop_s       = out_en;
            end
            DONE: begin
                wr_drop_s = out_en;
            end
            default: begin
                wr_drop_s = out_en;
            end
        endcase
    end

    // First drain payload sees a same-cycle write to entry 0.
    always_comb begin
        if (out_en && (write_addr == ZERO_IDX)) begin
            start_data_s = psum_in;
        end else begin
            start_data_s = mem_rd_b_data_s;
        end
    end

    // MAC feedback value, optionally forwarding the in-flight IDLE write.
    always_comb begin
`ifdef RF_PSUM_BYPASS_EN
        if ((state_r == IDLE) && out_en && !clear && (write_addr == read_addr)) begin
            sum_out_s = psum_in;
        end else begin
            sum_out_s = mem_rd_a_data_s;
        end
`else
        sum_out_s = mem_rd_a_data_s;
`endif
    end

    // Drain FSM with registered handshake, status and conflict outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            idx_r         <= ZERO_IDX;
            drain_data_r  <= {W{1'b0}};
            drain_addr_r  <= ZERO_IDX;
            drain_valid_r <= 1'b0;
            drain_done_r  <= 1'b0;
            busy_r        <= 1'b0;
            wr_conflict_r <= 1'b0;
        end else begin
            wr_conflict_r <= wr_drop_s;
            case (state_r)
                IDLE: begin
                    drain_done_r <= 1'b0;
                    if (!clear && drain_start) begin
                        state_r       <= DRAIN;
                        idx_r         <= ZERO_IDX;
                        drain_data_r  <= start_data_s;
                        drain_addr_r  <= ZERO_IDX;
                        drain_valid_r <= 1'b1;
                        busy_r        <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (handshake_s) begin
                        if (idx_r == LAST_IDX) begin
                            drain_valid_r <= 1'b0;
                            drain_done_r  <= 1'b1;
                            state_r       <= DONE;
                        end else begin
                            idx_r        <= idx_r + ONE_IDX;
                            drain_data_r <= mem_rd_b_data_s;
                            drain_addr_r <= idx_r + ONE_IDX;
                        end
                    end
                end
                DONE: begin
                    drain_done_r <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= IDLE;
                end
                default: begin
                    state_r       <= IDLE;
                    drain_valid_r <= 1'b0;
                    drain_done_r  <= 1'b0;
                    busy_r        <= 1'b0;
                end
            endcase
        end
    end

    assign sum_out     = sum_out_s;
    assign drain_data  = drain_data_r;
    assign drain_addr  = drain_addr_r;
    assign drain_valid = drain_valid_r;
    assign drain_done  = drain_done_r;
    assign busy        = busy_r;
    assign wr_conflict = wr_conflict_r;

endmodule : rf_psum_drain
